// File: rtl/graphics_pkg.sv
// Shared graphics types and constants for the fragment pipeline.
// Colour is RGB 4:4:4 with r in the most significant nibble.
package graphics_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam logic [9:0] COLOR_HASH_MULT = 10'd123;
  localparam int H_RES_DEFAULT = 320;
  localparam int V_RES_DEFAULT = 240;

endpackage

// File: rtl/depth_cue_scaler.sv
// Combinational depth cue for one 4-bit colour channel.
// Scales c by (2^Z_WIDTH - z) / 2^Z_WIDTH, so z = 0 is identity.
module depth_cue_scaler #(
  parameter int Z_WIDTH = 8
) (
  input  logic [3:0]         i_c,
  input  logic [Z_WIDTH-1:0] i_z,
  output logic [3:0]         o_c
);

  logic [Z_WIDTH:0]   w_weight;
  logic [Z_WIDTH+4:0] w_prod;
  logic               w_unused;

  assign w_weight = {1'b1, {Z_WIDTH{1'b0}}} - {1'b0, i_z};
  assign w_prod   = {{(Z_WIDTH+1){1'b0}}, i_c} * {4'b0, w_weight};
  assign o_c      = w_prod[Z_WIDTH+3:Z_WIDTH];
  assign w_unused = ^{w_prod[Z_WIDTH+4], w_prod[Z_WIDTH-1:0]};

endmodule

// File: rtl/fragment_shader_pipe.sv
// Three-stage fragment shader: clip, flat colour, optional depth cue.
// Build macro FRAGMENT_DEPTH_CUE_EN enables the stage-2 depth cue.
module fragment_shader_pipe
  import graphics_pkg::*;
#(
  parameter int COORD_WIDTH = 17,
  parameter int FRAC_BITS   = 8,
  parameter int X_WIDTH     = 9,
  parameter int Y_WIDTH     = 8,
  parameter int Z_WIDTH     = 8,
  parameter int ID_WIDTH    = 16,
  parameter int H_RES       = H_RES_DEFAULT,
  parameter int V_RES       = V_RES_DEFAULT,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic [ID_WIDTH-1:0]        triangle_id_in,
  input  logic [2:0][COORD_WIDTH-1:0] fragment_in,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic [X_WIDTH-1:0]         x_out,
  output logic [Y_WIDTH-1:0]         y_out,
  output logic [Z_WIDTH-1:0]         z_out,
  output logic [11:0]                rgb_out,
  output logic [CNT_WIDTH-1:0]       pixel_count_out,
  output logic [CNT_WIDTH-1:0]       drop_count_out
);

  localparam int IW = COORD_WIDTH - FRAC_BITS;
  localparam logic [IW-1:0] H_LIM = IW'(H_RES);
  localparam logic [IW-1:0] V_LIM = IW'(V_RES);

  logic                  w_adv;
  logic                  w_accept;
  logic                  w_clip;
  logic                  w_emit;
  logic                  w_unused;
  logic [IW-1:0]         w_xi;
  logic [IW-1:0]         w_yi;
  logic [ID_WIDTH-1:0]   w_nid;
  logic [ID_WIDTH+9:0]   w_hash;
  rgb444_t               w_base;
  rgb444_t               w_cued;

  logic                  r_s1_valid;
  logic [IW-1:0]         r_s1_xi;
  logic [IW-1:0]         r_s1_yi;
  logic [Z_WIDTH-1:0]    r_s1_z;
  rgb444_t               r_s1_rgb;

  logic                  r_s2_valid;
  logic [X_WIDTH-1:0]    r_s2_x;
  logic [Y_WIDTH-1:0]    r_s2_y;
  logic [Z_WIDTH-1:0]    r_s2_z;
  rgb444_t               r_s2_rgb;

  assign w_xi     = fragment_in[0][COORD_WIDTH-1:FRAC_BITS];
  assign w_yi     = fragment_in[1][COORD_WIDTH-1:FRAC_BITS];
  assign w_nid    = ~triangle_id_in;
  assign w_hash   = {10'b0, w_nid} * {{ID_WIDTH{1'b0}}, COLOR_HASH_MULT};
  assign w_base   = w_hash[11:0];
  assign w_adv    = !valid_out || ready_in;
  assign ready_out = rst_n_in && w_adv;
  assign w_accept = valid_in && ready_out;
  assign w_clip   = (r_s1_xi >= H_LIM) || (r_s1_yi >= V_LIM);
  assign w_emit   = valid_out && ready_in;
  assign w_unused = ^{fragment_in, w_hash[ID_WIDTH+9:12]};

`ifdef FRAGMENT_DEPTH_CUE_EN
  logic [3:0] w_cue_r;
  logic [3:0] w_cue_g;
  logic [3:0] w_cue_b;

  depth_cue_scaler #(.Z_WIDTH(Z_WIDTH)) u_cue_r (
    .i_c(r_s2_rgb.r), .i_z(r_s2_z), .o_c(w_cue_r)
  );
  depth_cue_scaler #(.Z_WIDTH(Z_WIDTH)) u_cue_g (
    .i_c(r_s2_rgb.g), .i_z(r_s2_z), .o_c(w_cue_g)
  );
  depth_cue_scaler #(.Z_WIDTH(Z_WIDTH)) u_cue_b (
    .i_c(r_s2_rgb.b), .i_z(r_s2_z), .o_c(w_cue_b)
  );

  assign w_cued = {w_cue_r, w_cue_g, w_cue_b};
`else
  assign w_cued = r_s2_rgb;
`endif

  // S1: capture fragment integer coords, depth and base colour
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_s1_valid <= 1'b0;
      r_s1_xi    <= '0;
      r_s1_yi    <= '0;
      r_s1_z     <= '0;
      r_s1_rgb   <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      r_s1_xi    <= w_xi;
      r_s1_yi    <= w_yi;
      r_s1_z     <= fragment_in[2][FRAC_BITS+Z_WIDTH-1:FRAC_BITS];
      r_s1_rgb   <= w_base;
    end
  end

  // S2: clipped fragments become bubbles here
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_s2_valid <= 1'b0;
      r_s2_x     <= '0;
      r_s2_y     <= '0;
      r_s2_z     <= '0;
      r_s2_rgb   <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid && !w_clip;
      r_s2_x     <= r_s1_xi[X_WIDTH-1:0];
      r_s2_y     <= r_s1_yi[Y_WIDTH-1:0];
      r_s2_z     <= r_s1_z;
      r_s2_rgb   <= r_s1_rgb;
    end
  end

  // S3: registered pixel output, holds while downstream stalls
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      valid_out <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      rgb_out   <= '0;
    end else if (w_adv) begin
      valid_out <= r_s2_valid;
      x_out     <= r_s2_x;
      y_out     <= r_s2_y;
      z_out     <= r_s2_z;
      rgb_out   <= w_cued;
    end
  end

  // Saturating debug counters for emitted pixels and clipped fragments
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pixel_count_out <= '0;
      drop_count_out  <= '0;
    end else begin
      if (w_emit && (pixel_count_out != '1))
        pixel_count_out <= pixel_count_out + CNT_WIDTH'(1);
      if (w_adv && r_s1_valid && w_clip && (drop_count_out != '1))
        drop_count_out <= drop_count_out + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fragment_shader_pipe.sv
// Directed bench for fragment_shader_pipe (counters built 4 bits wide).
// Expectations follow FRAGMENT_DEPTH_CUE_EN when it is defined.
module tb_fragment_shader_pipe;

`ifdef FRAGMENT_DEPTH_CUE_EN
  localparam bit CUE = 1'b1;
`else
  localparam bit CUE = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             valid_in;
  logic             ready_out;
  logic [15:0]      triangle_id_in;
  logic [2:0][16:0] fragment_in;
  logic             valid_out;
  logic             ready_in;
  logic [8:0]       x_out;
  logic [7:0]       y_out;
  logic [7:0]       z_out;
  logic [11:0]      rgb_out;
  logic [3:0]       pixel_count_out;
  logic [3:0]       drop_count_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  fragment_shader_pipe #(.CNT_WIDTH(4)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .triangle_id_in(triangle_id_in),
    .fragment_in(fragment_in),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .x_out(x_out),
    .y_out(y_out),
    .z_out(z_out),
    .rgb_out(rgb_out),
    .pixel_count_out(pixel_count_out),
    .drop_count_out(drop_count_out)
  );

  typedef struct {
    logic [15:0] id;
    logic [16:0] fx;
    logic [16:0] fy;
    logic [16:0] fz;
    logic        ev;
    logic [8:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  ez;
    logic [11:0] ergb;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    triangle_id_in = v.id;
    fragment_in[0] = v.fx;
    fragment_in[1] = v.fy;
    fragment_in[2] = v.fz;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    step();
    chk("lat_early", 32'(valid_out), 32'd0);
    step();
    chk("valid", 32'(valid_out), 32'(v.ev));
    if (v.ev) begin
      chk("x", 32'(x_out), 32'(v.ex));
      chk("y", 32'(y_out), 32'(v.ey));
      chk("z", 32'(z_out), 32'(v.ez));
      chk("rgb", 32'(rgb_out), 32'(v.ergb));
    end
    step();
    chk("pulse", 32'(valid_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int recv;
    int stall_left;
    bit seen;
    bit acc;
    bit emit;
    logic [8:0]  sx;
    logic [11:0] srgb;

    tbl[0] = '{16'h0000, 17'h00A00, 17'h01400, 17'h08000, 1'b1,
               9'd10, 8'd20, 8'h80, CUE ? 12'h742 : 12'hF85};
    tbl[1] = '{16'h0000, 17'h00A00, 17'h01400, 17'h00000, 1'b1,
               9'd10, 8'd20, 8'h00, 12'hF85};
    tbl[2] = '{16'h0001, 17'h13F80, 17'h0EFFF, 17'h0FF00, 1'b1,
               9'd319, 8'd239, 8'hFF, CUE ? 12'h000 : 12'hF0A};
    tbl[3] = '{16'hFFFF, 17'h00000, 17'h00000, 17'h04000, 1'b1,
               9'd0, 8'd0, 8'h40, 12'h000};
    tbl[4] = '{16'h1234, 17'h0640A, 17'h03280, 17'h0C000, 1'b1,
               9'd100, 8'd50, 8'hC0, CUE ? 12'h022 : 12'h089};
    tbl[5] = '{16'h0000, 17'h14000, 17'h01400, 17'h00000, 1'b0,
               9'd0, 8'd0, 8'h00, 12'h000};
    tbl[6] = '{16'h0000, 17'h00A00, 17'h0F000, 17'h00000, 1'b0,
               9'd0, 8'd0, 8'h00, 12'h000};

    rst_n_in = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    triangle_id_in = '0;
    fragment_in = '0;
    step();
    step();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_pix", 32'(pixel_count_out), 32'd0);
    chk("rst_drop", 32'(drop_count_out), 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    rst_n_in = 1'b1;
    #1;
    chk("ready_after_rst", 32'(ready_out), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);
    chk("pix_after_table", 32'(pixel_count_out), 32'd5);
    chk("drop_after_table", 32'(drop_count_out), 32'd2);

    sent = 0;
    recv = 0;
    stall_left = 0;
    seen = 1'b0;
    sx = '0;
    srgb = '0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      if (!seen && valid_out) begin
        seen = 1'b1;
        stall_left = 5;
      end
      ready_in = (stall_left == 0);
      if (sent < 6) begin
        valid_in = 1'b1;
        triangle_id_in = 16'(sent);
        fragment_in[0] = 17'(sent << 8);
        fragment_in[1] = 17'(sent << 8);
        fragment_in[2] = '0;
      end else begin
        valid_in = 1'b0;
      end
      #1;
      acc = valid_in && ready_out;
      emit = valid_out && ready_in;
      if (stall_left == 5) begin
        sx = x_out;
        srgb = rgb_out;
      end
      if (stall_left > 0) begin
        chk("bp_ready", 32'(ready_out), 32'd0);
        if (stall_left < 5) begin
          chk("bp_hold_x", 32'(x_out), 32'(sx));
          chk("bp_hold_rgb", 32'(rgb_out), 32'(srgb));
        end
        stall_left--;
      end
      if (emit) begin
        chk("bp_order", 32'(x_out), 32'(recv));
        chk("bp_rgb", 32'(rgb_out), 32'(4096 - 123 * (recv + 1)));
        recv++;
      end
      @(posedge clk_in);
      #1;
      if (acc) sent++;
    end
    chk("bp_received", 32'(recv), 32'd6);
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    chk("bp_no_dup", 32'(valid_out), 32'd0);
    chk("pix_after_bp", 32'(pixel_count_out), 32'd11);

    for (int k = 0; k < 3; k++) begin
      triangle_id_in = 16'(k + 10);
      fragment_in[0] = 17'((k + 1) << 8);
      fragment_in[1] = 17'h00100;
      fragment_in[2] = '0;
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    rst_n_in = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_out), 32'd0);
    step();
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_pix", 32'(pixel_count_out), 32'd0);
    chk("midrst_drop", 32'(drop_count_out), 32'd0);
    rst_n_in = 1'b1;
    step();
    chk("flush_1", 32'(valid_out), 32'd0);
    step();
    chk("flush_2", 32'(valid_out), 32'd0);
    run_vec(tbl[0]);
    chk("pix_after_rst", 32'(pixel_count_out), 32'd1);

    triangle_id_in = 16'h0000;
    fragment_in[0] = 17'h00A00;
    fragment_in[1] = 17'h01400;
    fragment_in[2] = 17'h00000;
    valid_in = 1'b1;
    for (int k = 0; k < 20; k++) step();
    valid_in = 1'b0;
    step();
    step();
    step();
    chk("sat_pix", 32'(pixel_count_out), 32'hF);
    chk("sat_drop", 32'(drop_count_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fragment_shader_pipe.md
# fragment_shader_pipe

Parametrised, pipelined fragment shader between the rasteriser and the frame/depth buffer writer. It accepts fixed-point fragments tagged with a triangle ID, drops fragments outside the screen, and generates a per-triangle flat colour. When compiled in, it also applies a depth cue to that colour. Output is a registered pixel stream under a valid/ready handshake, with saturating pixel and drop counters for debug.

## Interface
- COORD_WIDTH, 17: width of each fragment coordinate, unsigned fixed point
- FRAC_BITS, 8: fractional bits per coordinate
- X_WIDTH, 9: output x width
- Y_WIDTH, 8: output y width
- Z_WIDTH, 8: output z width
- ID_WIDTH, 16: triangle ID width
- H_RES, 320: horizontal resolution; x ≥ H_RES is clipped
- V_RES, 240: vertical resolution; y ≥ V_RES is clipped
- CNT_WIDTH, 16: width of the debug counters

Ports:
- clk_in  input  1  single clock
- rst_n_in  input  1  reset, synchronous, active-low
- valid_in  input  1  fragment valid
- ready_out  output  1  block can accept a fragment
- triangle_id_in  input  ID_WIDTH  source triangle
- fragment_in  input  [2:0][COORD_WIDTH]  {z, y, x}, with x at index 0
- valid_out  output  1  pixel valid
- ready_in  input  1  downstream accepts the pixel
- x_out  output  X_WIDTH  pixel x
- y_out  output  Y_WIDTH  pixel y
- z_out  output  Z_WIDTH  pixel depth
- rgb_out  output  12  RGB 4:4:4 colour
- pixel_count_out  output  CNT_WIDTH  pixels emitted, saturating
- drop_count_out  output  CNT_WIDTH  fragments clipped, saturating

## Operation
- **Accept:** a fragment is accepted on any edge where valid_in && ready_out.
- **Integer parts:** xi = fragment_in[0][COORD_WIDTH-1:FRAC_BITS] and yi = fragment_in[1][COORD_WIDTH-1:FRAC_BITS]. Both are kept at full width for the clip test.
- **Clip:** the fragment is dropped if xi ≥ H_RES or yi ≥ V_RES.
  - A dropped fragment becomes a bubble in stage 2, so no output is produced.
  - drop_count_out increments.
- **Output coordinates:**
  - x_out = xi[X_WIDTH-1:0]
  - y_out = yi[Y_WIDTH-1:0]
  - z_out = fragment_in[2][FRAC_BITS+Z_WIDTH-1:FRAC_BITS]
- **Base colour:** (~triangle_id_in) * 10'd123, truncated to 12 bits.
- **Depth cue:** each 4-bit channel c becomes (c * (2^Z_WIDTH − z)) >> Z_WIDTH.
  - The weight is Z_WIDTH+1 bits wide.
  - z = 0 leaves the colour unchanged; z = 2^Z_WIDTH−1 gives 0.
- **Counters:**
  - pixel_count_out increments on each valid_out && ready_in.
  - Both counters saturate at all-ones and clear only on reset.

## Timing
- **Pipeline:** three stages.
  - S1: input register, clip test, base colour.
  - S2: depth-cue multiply.
  - S3: output register.
- **Latency:** an accepted, unclipped fragment appears on valid_out exactly 3 cycles later when there is no stall.
- **Throughput:** one fragment per cycle.
- **Stall:** ready_out = rst_n_in && (!valid_out || ready_in), which is combinational.
  - While valid_out && !ready_in, all stages hold. Outputs stay stable and no fragment is lost or reordered.
  - Bubbles are not squeezed out during a stall.
- **Simultaneous events:** an accept and an emit in the same cycle are both honoured. A counter increment and saturation in the same cycle leaves the counter at all-ones.
- **Reset:** while rst_n_in = 0 at an edge:
  - all stage valids clear;
  - valid_out, x_out, y_out, z_out, rgb_out and both counters become 0;
  - ready_out is 0 during reset.
  - Reset mid-stream discards all in-flight fragments; the next cycle after release accepts normally.

## Configuration
- **FRAGMENT_DEPTH_CUE_EN defined:** the depth-cue multiply in S2 is active.
- **FRAGMENT_DEPTH_CUE_EN undefined:** S2 passes the base colour unchanged.
- The pipeline depth stays 3 cycles in both builds, so downstream timing is identical.

## Structure
- **Shared package graphics_pkg:**
  - rgb444_t, a packed struct with 4-bit r, g and b fields;
  - the colour-hash constant COLOR_HASH_MULT = 10'd123;
  - default H_RES and V_RES.
- **Sub-module depth_cue_scaler:** one instance per channel, combinational, taking c and z and returning the scaled channel. It is instantiated only under FRAGMENT_DEPTH_CUE_EN.

## Test plan
- **Single fragment, no cue build:**
  - Stimulus: id 0, fragment {0x08000, 0x01400, 0x00A00}, ready_in = 1.
  - Response: 3 cycles later valid_out for one cycle with x=10, y=20, z=0x80, rgb=0xF85; pixel_count_out=1.
- **Depth cue build:**
  - Same fragment gives rgb=0x742.
  - Same fragment with z field 0 gives rgb=0xF85.
- **Clip:**
  - Stimulus: x=0x14000 (320), then y=0x0F000 (240).
  - Response: no valid_out; drop_count_out=2; pixel_count_out unchanged.
- **Backpressure:**
  - Stimulus: stream 6 fragments with ids 0–5; hold ready_in low for 5 cycles starting when the first pixel appears.
  - Response: ready_out drops; outputs stay stable while stalled; all 6 emerge in order with no duplicates.
- **Reset mid-stream:**
  - Stimulus: 3 fragments in flight, then rst_n_in low for one cycle.
  - Response: valid_out=0 and counters=0 on the next cycle; a fresh fragment then emerges with latency 3.
- **Saturation:**
  - Stimulus: with CNT_WIDTH=4, emit 20 pixels.
  - Response: pixel_count_out holds 0xF.
